ptw_req_arbiter: RTL and testbench
==================================

Name: ptw_req_arbiter

Overview:
- Shares the single page-table walker (PTW) among N TLB requesters, for example the ITLB and the DTLB ports.
- Picks one request by round-robin, issues it to the PTW and tracks exactly one walk in flight.
- Registers the returned PTE (ppn, d, a, g, u, x, w, r, v) and returns it only to the requester that owns the walk.
- An sfence flush kills the walk in flight, so a stale PTE never reaches a TLB.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- VPN_W, 27, virtual page number width.
- PPN_W, 44, physical page number width.

Ports:
- clock  in  1  single clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester walk request.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_vpn  in  N_REQ*VPN_W  requester i occupies bits [i*VPN_W +: VPN_W].
- ptw_req_valid  out  1  walk request to the PTW.
- ptw_req_ready  in  1  PTW accepts the request.
- ptw_req_vpn  out  VPN_W  registered VPN of the granted request.
- ptw_resp_valid  in  1  one-cycle pulse: walk done.
- ptw_resp_ae  in  1  access exception on the walk.
- ptw_resp_ppn  in  PPN_W  returned PTE ppn.
- ptw_resp_flags  in  8  returned PTE flags {d,a,g,u,x,w,r,v}, with d as the MSB.
- resp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- resp_ae  out  1  registered ae.
- resp_ppn  out  PPN_W  registered ppn.
- resp_flags  out  8  registered flags.
- sfence  in  1  flush: kill the walk in flight.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - killed flag, resp_valid, ptw_req_valid, ptw_req_vpn, resp_ae, resp_ppn and resp_flags all go to 0.
  - Asserting reset mid-walk abandons the walk. Any later ptw_resp_valid that arrives while the FSM is in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i] set, searching from the pointer upward with wrap-around.
  - req_ready[g] is high in the same cycle (combinational). No grant is made while sfence is high.
  - On the handshake: latch the VPN and owner=g, set the pointer to (g+1) mod N_REQ, clear killed, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - ptw_req_valid is high.
  - ptw_req_ready high -> go to WAIT.
  - sfence high and ptw_req_ready low -> go to IDLE, nothing issued.
  - sfence high and ptw_req_ready high in the same cycle -> go to WAIT with killed=1.
- WAIT:
  - sfence sets killed=1.
  - On ptw_resp_valid: register ae, ppn and flags, then go to RESP if killed is 0 (and sfence is low this cycle), otherwise go to IDLE.
  - ptw_resp_valid arriving in IDLE, ISSUE or RESP is ignored.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle, then go to IDLE.
  - resp data stays stable until the next response is captured.
  - sfence in RESP does not suppress the strobe, because the PTE was captured before the flush.
- Latency:
  - Request handshake to ptw_req_valid: 1 cycle.
  - ptw_resp_valid to resp_valid: 1 cycle.
  - Minimum turnaround of one request: 4 cycles with an immediate PTW.
- Fairness: a requester that holds req_valid is granted within N_REQ grants.
- busy is high whenever the state is not IDLE.

Decomposition:
- Shared package ptw_pkg holds:
  - pte_flags_t, a packed struct {d,a,g,u,x,w,r,v};
  - the state enum arb_state_e;
  - default width constants VPN_W_DEF=27 and PPN_W_DEF=44.
- One sub-module, rr_grant: a combinational round-robin picker that takes the request vector and the pointer and returns a one-hot grant plus a valid bit. It is reusable by other arbiters.

Test Plan:
1. Single request: req_valid=01, vpn=0x1234567, PTW ready at once, response 2 cycles later with ppn=0xABC and flags=0xCF -> ptw_req_vpn=0x1234567; resp_valid=01 with ppn=0xABC and flags=0xCF exactly one cycle after ptw_resp_valid.
2. Contention: req_valid=11 held continuously -> grant order is 0,1,0,1 across four walks; resp_valid alternates 01,10,01,10.
3. sfence in WAIT, then ptw_resp_valid -> no resp_valid bit asserts, FSM returns to IDLE, and the next request is serviced normally.
4. sfence in ISSUE with ptw_req_ready=0 -> ptw_req_valid drops the next cycle and the FSM goes to IDLE. Repeat with ptw_req_ready=1 in the same cycle -> FSM goes to WAIT, the response is swallowed and resp_valid stays 0.
5. Reset driven low during WAIT, then released, then a stray ptw_resp_valid -> all outputs are 0 and no resp_valid fires; the pointer is 0, so with req_valid=11 requester 0 is granted first.
6. Spurious ptw_resp_valid while in IDLE and in RESP -> resp registers unchanged, no extra resp_valid.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared types for the page-table-walker request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ptw_pkg;

  localparam int VPN_W_DEF = 27;
  localparam int PPN_W_DEF = 44;

  // PTE permission/status bits, d is the MSB.
  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ptw_req_arbiter_rr_grant.sv
// Round-robin picker: first set request at or above the pointer, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_grant #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  logic [PTR_W:0] w_idx;

  // Scan N slots starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(N)) begin
        w_idx = w_idx - (PTR_W+1)'(N);
      end
      if (!o_valid && i_req[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        o_valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker among N_REQ TLBs; one walk in flight, sfence kills it.
// Latency: grant->ptw_req_valid 1 cycle, ptw_resp_valid->resp_valid 1 cycle, 4-cycle minimum turnaround.
// Backpressure: req_ready only in IDLE with sfence low; ISSUE holds ptw_req_valid until ptw_req_ready.
module ptw_req_arbiter
  import ptw_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int VPN_W = VPN_W_DEF,
  parameter int PPN_W = PPN_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*VPN_W-1:0] req_vpn,
  output logic                   ptw_req_valid,
  input  logic                   ptw_req_ready,
  output logic [VPN_W-1:0]       ptw_req_vpn,
  input  logic                   ptw_resp_valid,
  input  logic                   ptw_resp_ae,
  input  logic [PPN_W-1:0]       ptw_resp_ppn,
  input  logic [7:0]             ptw_resp_flags,
  output logic [N_REQ-1:0]       resp_valid,
  output logic                   resp_ae,
  output logic [PPN_W-1:0]       resp_ppn,
  output logic [7:0]             resp_flags,
  input  logic                   sfence,
  output logic                   busy
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_e       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_owner;
  logic             r_killed;
  logic [N_REQ-1:0] r_resp_valid;
  logic             r_ptw_req_valid;
  logic [VPN_W-1:0] r_ptw_req_vpn;
  logic             r_resp_ae;
  logic [PPN_W-1:0] r_resp_ppn;
  pte_flags_t       r_resp_flags;

  logic [N_REQ-1:0] w_grant;
  logic             w_grant_any;
  logic             w_hs;
  logic [PTR_W-1:0] w_grant_idx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [VPN_W-1:0] w_sel_vpn;

  rr_grant #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_any)
  );

  // A grant is only offered from IDLE and never while a flush is in progress.
  assign w_hs      = (r_state == IDLE) && !sfence && w_grant_any;
  assign req_ready = w_hs ? w_grant : '0;

  // Turn the one-hot grant into an index and pick the matching VPN slice.
  always_comb begin
    w_grant_idx = '0;
    w_sel_vpn   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_grant_idx = PTR_W'(k);
        w_sel_vpn   = req_vpn[k*VPN_W +: VPN_W];
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  assign w_ptr_nxt = (w_grant_idx == PTR_W'(N_REQ-1)) ? '0 : w_grant_idx + PTR_W'(1);

  // Walk-tracking FSM with registered PTW request and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_ptr           <= '0;
      r_owner         <= '0;
      r_killed        <= 1'b0;
      r_resp_valid    <= '0;
      r_ptw_req_valid <= 1'b0;
      r_ptw_req_vpn   <= '0;
      r_resp_ae       <= 1'b0;
      r_resp_ppn      <= '0;
      r_resp_flags    <= '0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_ptw_req_vpn   <= w_sel_vpn;
            r_owner         <= w_grant;
            r_ptr           <= w_ptr_nxt;
            r_killed        <= 1'b0;
            r_ptw_req_valid <= 1'b1;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (ptw_req_ready) begin
            // A flush racing the accept still lets the walk run, but it is doomed.
            r_ptw_req_valid <= 1'b0;
            r_state         <= WAIT;
            if (sfence) begin
              r_killed <= 1'b1;
            end
          end else if (sfence) begin
            r_ptw_req_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end
        WAIT: begin
          if (ptw_resp_valid) begin
            r_resp_ae    <= ptw_resp_ae;
            r_resp_ppn   <= ptw_resp_ppn;
            r_resp_flags <= pte_flags_t'(ptw_resp_flags);
            if (!r_killed && !sfence) begin
              r_resp_valid <= r_owner;
              r_state      <= RESP;
            end else begin
              r_state <= IDLE;
            end
          end else if (sfence) begin
            r_killed <= 1'b1;
          end
        end
        RESP: begin
          // The PTE was captured before any flush seen here, so the strobe stands.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ptw_req_valid = r_ptw_req_valid;
  assign ptw_req_vpn   = r_ptw_req_vpn;
  assign resp_valid    = r_resp_valid;
  assign resp_ae       = r_resp_ae;
  assign resp_ppn      = r_resp_ppn;
  assign resp_flags    = r_resp_flags;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: table of walks plus hand sequences for flush/reset corners.
// Latency: n/a.
// Backpressure: PTW accept delay and response delay are per-vector.
module tb_ptw_req_arbiter;

  localparam int N  = 2;
  localparam int VW = 27;
  localparam int PW = 44;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*VW-1:0] req_vpn;
  logic          ptw_req_valid;
  logic          ptw_req_ready;
  logic [VW-1:0] ptw_req_vpn;
  logic          ptw_resp_valid;
  logic          ptw_resp_ae;
  logic [PW-1:0] ptw_resp_ppn;
  logic [7:0]    ptw_resp_flags;
  logic [N-1:0]  resp_valid;
  logic          resp_ae;
  logic [PW-1:0] resp_ppn;
  logic [7:0]    resp_flags;
  logic          sfence;
  logic          busy;

  ptw_req_arbiter #(.N_REQ(N), .VPN_W(VW), .PPN_W(PW)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vpn        (req_vpn),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_ae    (ptw_resp_ae),
    .ptw_resp_ppn   (ptw_resp_ppn),
    .ptw_resp_flags (ptw_resp_flags),
    .resp_valid     (resp_valid),
    .resp_ae        (resp_ae),
    .resp_ppn       (resp_ppn),
    .resp_flags     (resp_flags),
    .sfence         (sfence),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    rv;
    logic [VW-1:0] vpn0;
    logic [VW-1:0] vpn1;
    int            rdy_wait;
    int            resp_wait;
    bit            sf_wait;
    bit            spur_resp;
    logic          ae;
    logic [PW-1:0] ppn;
    logic [7:0]    flags;
    int            exp_g;
    bit            exp_resp;
  } vec_t;

  typedef struct packed {
    logic [N-1:0]  rv;
    logic          ae;
    logic [PW-1:0] ppn;
    logic [7:0]    flags;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];
  vec_t hv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every response strobe must match the oldest expected walk result.
  always @(negedge clock) begin
    if (resp_valid !== '0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: resp_valid=%b with nothing expected at %0t", resp_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_valid, resp_ae, resp_ppn, resp_flags} !== mon_e) begin
          n_err++;
          $display("FAIL sb_resp: got rv=%b ae=%b ppn=0x%0h flags=0x%0h expected rv=%b ae=%b ppn=0x%0h flags=0x%0h",
                   resp_valid, resp_ae, resp_ppn, resp_flags, mon_e.rv, mon_e.ae, mon_e.ppn, mon_e.flags);
        end
      end
    end
  end

  // One complete walk, entered and left in an IDLE cycle.
  task automatic run_txn(input vec_t v);
    logic [VW-1:0] ev;
    logic [N-1:0]  eg;
    exp_t          e;
    ev = (v.exp_g == 0) ? v.vpn0 : v.vpn1;
    eg = N'(1 << v.exp_g);
    req_valid      = v.rv;
    req_vpn        = {v.vpn1, v.vpn0};
    sfence         = 1'b0;
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b0;
    #1;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("grant", 64'(req_ready), 64'(eg));
    tick();
    #1;
    chk("issue_valid", 64'(ptw_req_valid), 64'(1));
    chk("issue_vpn", 64'(ptw_req_vpn), 64'(ev));
    chk("issue_no_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < v.rdy_wait; i++) begin
      tick();
      #1;
      chk("issue_hold", 64'(ptw_req_valid), 64'(1));
    end
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    #1;
    chk("wait_req_lo", 64'(ptw_req_valid), 64'(0));
    chk("wait_busy", 64'(busy), 64'(1));
    for (int i = 0; i < v.resp_wait; i++) begin
      sfence = v.sf_wait && (i == 0);
      tick();
      sfence = 1'b0;
    end
    chk("wait_no_strobe", 64'(resp_valid), 64'(0));
    ptw_resp_valid = 1'b1;
    ptw_resp_ae    = v.ae;
    ptw_resp_ppn   = v.ppn;
    ptw_resp_flags = v.flags;
    if (v.exp_resp) begin
      e.rv    = eg;
      e.ae    = v.ae;
      e.ppn   = v.ppn;
      e.flags = v.flags;
      sb.push_back(e);
    end
    tick();
    ptw_resp_valid = 1'b0;
    ptw_resp_ae    = ~v.ae;
    ptw_resp_ppn   = ~v.ppn;
    ptw_resp_flags = ~v.flags;
    #1;
    if (v.exp_resp) begin
      chk("resp_strobe", 64'(resp_valid), 64'(eg));
      chk("resp_ppn", 64'(resp_ppn), 64'(v.ppn));
      chk("resp_flags", 64'(resp_flags), 64'(v.flags));
      chk("resp_ae", 64'(resp_ae), 64'(v.ae));
      if (v.spur_resp) ptw_resp_valid = 1'b1;
      tick();
      ptw_resp_valid = 1'b0;
      #1;
      chk("resp_one_cycle", 64'(resp_valid), 64'(0));
      chk("resp_stable_ppn", 64'(resp_ppn), 64'(v.ppn));
      chk("resp_stable_flags", 64'(resp_flags), 64'(v.flags));
      chk("back_idle", 64'(busy), 64'(0));
    end else begin
      chk("killed_no_strobe", 64'(resp_valid), 64'(0));
      chk("killed_idle", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rv     vpn0          vpn1         rdy rsp sf spur ae    ppn                 flags  g resp
    tbl[0] = '{2'b01, 27'h1234567, 27'h0000000, 0, 1, 0, 0, 1'b0, 44'h000_0000_0ABC, 8'hCF, 0, 1};
    tbl[1] = '{2'b10, 27'h0000111, 27'h7654321, 1, 0, 0, 0, 1'b1, 44'h123_4567_89AB, 8'h01, 1, 1};
    tbl[2] = '{2'b11, 27'h2AAAAAA, 27'h5555555, 0, 0, 0, 0, 1'b0, 44'hFFF_FFFF_FFFF, 8'hFF, 0, 1};
    tbl[3] = '{2'b11, 27'h2AAAAAA, 27'h5555555, 2, 3, 0, 0, 1'b0, 44'h000_0000_0001, 8'h80, 1, 1};
    tbl[4] = '{2'b11, 27'h2AAAAAA, 27'h5555555, 0, 1, 0, 0, 1'b1, 44'h800_0000_0000, 8'h3A, 0, 1};
    tbl[5] = '{2'b11, 27'h2AAAAAA, 27'h5555555, 0, 1, 0, 1, 1'b0, 44'h000_0000_4444, 8'h55, 1, 1};
    tbl[6] = '{2'b01, 27'h0DEAD00, 27'h0BEEF00, 0, 2, 1, 0, 1'b0, 44'h000_0000_DEAD, 8'hC1, 0, 0};
    tbl[7] = '{2'b11, 27'h0DEAD00, 27'h0BEEF00, 0, 1, 0, 0, 1'b0, 44'h000_0000_0777, 8'h0F, 1, 1};

    reset          = 1'b0;
    req_valid      = '0;
    req_vpn        = '0;
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b0;
    ptw_resp_ae    = 1'b0;
    ptw_resp_ppn   = '0;
    ptw_resp_flags = '0;
    sfence         = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ptw_req_valid", 64'(ptw_req_valid), 64'(0));
    chk("rst_ptw_req_vpn", 64'(ptw_req_vpn), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'({resp_ae, resp_ppn, resp_flags}), 64'(0));
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
    end

    // No grant while sfence is high in IDLE (pointer is 0 here).
    req_valid = 2'b01;
    req_vpn   = {27'h0, 27'h0101010};
    sfence    = 1'b1;
    #1;
    chk("sf_idle_no_grant", 64'(req_ready), 64'(0));
    tick();
    #1;
    chk("sf_idle_stay", 64'(busy), 64'(0));

    // sfence in ISSUE with the PTW not ready: request withdrawn, back to IDLE.
    sfence = 1'b0;
    #1;
    chk("h1_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    #1;
    chk("h1_issue", 64'(ptw_req_valid), 64'(1));
    sfence        = 1'b1;
    ptw_req_ready = 1'b0;
    tick();
    sfence = 1'b0;
    #1;
    chk("h1_req_dropped", 64'(ptw_req_valid), 64'(0));
    chk("h1_idle", 64'(busy), 64'(0));

    // sfence and accept together: walk runs but its response is swallowed.
    req_valid = 2'b11;
    req_vpn   = {27'h0303030, 27'h0202020};
    #1;
    chk("h2_grant", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = '0;
    #1;
    chk("h2_issue_vpn", 64'(ptw_req_vpn), 64'(27'h0303030));
    sfence        = 1'b1;
    ptw_req_ready = 1'b1;
    tick();
    sfence        = 1'b0;
    ptw_req_ready = 1'b0;
    #1;
    chk("h2_wait", 64'(busy), 64'(1));
    ptw_resp_valid = 1'b1;
    ptw_resp_ppn   = 44'h999;
    ptw_resp_flags = 8'hA5;
    tick();
    ptw_resp_valid = 1'b0;
    #1;
    chk("h2_no_strobe", 64'(resp_valid), 64'(0));
    chk("h2_idle", 64'(busy), 64'(0));

    // Reset asserted mid-walk, then a stray response after release.
    req_valid = 2'b01;
    req_vpn   = {27'h0505050, 27'h0404040};
    #1;
    chk("h3_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid     = '0;
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    #1;
    chk("h3_in_wait", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("h3_rst_busy", 64'(busy), 64'(0));
    chk("h3_rst_ptw_req", 64'({ptw_req_valid, ptw_req_vpn}), 64'(0));
    chk("h3_rst_resp", 64'({resp_valid, resp_ae, resp_ppn, resp_flags}), 64'(0));
    tick();
    reset = 1'b1;
    tick();
    ptw_resp_valid = 1'b1;
    ptw_resp_ae    = 1'b1;
    ptw_resp_ppn   = 44'h0BAD;
    ptw_resp_flags = 8'hFF;
    tick();
    ptw_resp_valid = 1'b0;
    #1;
    chk("h3_stray_no_strobe", 64'(resp_valid), 64'(0));
    chk("h3_stray_ignored", 64'({resp_ae, resp_ppn, resp_flags}), 64'(0));
    chk("h3_stray_idle", 64'(busy), 64'(0));

    // Pointer back at 0 after reset: requester 0 wins contention.
    hv = '{2'b11, 27'h0606060, 27'h0707070, 0, 1, 0, 0, 1'b1, 44'h000_0000_2468, 8'hC3, 0, 1};
    run_txn(hv);

    // Spurious response while IDLE: registers and strobe untouched.
    req_valid      = '0;
    ptw_resp_valid = 1'b1;
    ptw_resp_ae    = 1'b0;
    ptw_resp_ppn   = 44'h1357;
    ptw_resp_flags = 8'h11;
    tick();
    ptw_resp_valid = 1'b0;
    #1;
    chk("h4_idle_ppn", 64'(resp_ppn), 64'(44'h2468));
    chk("h4_idle_flags", 64'({resp_ae, resp_flags}), 64'({1'b1, 8'hC3}));
    chk("h4_idle_busy", 64'(busy), 64'(0));
    tick();
    #1;
    chk("h4_no_strobe", 64'(resp_valid), 64'(0));

    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
